inst_fetch: RTL and testbench

//   Fetch stage directly downstream of the program counter. Reads the 9-bit instruction at PC from
//   a synchronous instruction ROM and registers it for decode. Exposes the opcode field, which is
//   fed back to the PC block for branch resolution. Handles decode stall, taken-branch flush and

---
 rtl/inst_fetch_pkg.sv | 20 ++
 rtl/inst_rom.sv | 31 +++
 rtl/inst_fetch.sv | 135 +++++++++++++
 tb/tb_inst_fetch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, the HALT opcode,
// the NOP encoding and the branch opcodes decoded by the pc block.
package inst_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALTED
   } fetch_state_t;

   localparam logic [4:0] OP_HALT = 5'b11111;
   localparam logic [8:0] NOP     = 9'h000;

   // Branch opcodes resolved by the pc block from op
   localparam logic [4:0] BA = 5'b10000;
   localparam logic [4:0] BL = 5'b10001;
   localparam logic [4:0] BG = 5'b10010;
   localparam logic [4:0] BE = 5'b10011;

endpackage

// File: rtl/inst_rom.sv
// Synchronous instruction ROM.
//   clk   - rising-edge clock
//   addr  - 8-bit fetch address (pc)
//   rd_en - sample addr this edge; data holds otherwise
//   data  - registered instruction; addresses >= DEPTH read as NOP
// Contents are loaded into mem by the environment (e.g. hierarchically).
module inst_rom
   import inst_fetch_pkg::*;
#(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned IW        = 9,
   parameter string       INIT_FILE = "machine_code.txt"
) (
   input  logic          clk,
   input  logic [7:0]    addr,
   input  logic          rd_en,
   output logic [IW-1:0] data
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [IW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rd_en) begin
         if (32'(addr) < DEPTH) data <= mem[addr[AW-1:0]];
         else                   data <= IW'(NOP);
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: reads the instruction at pc from inst_rom, registers it for
// decode, and handles stall, flush and HALT.
//   clk, reset  - clock, asynchronous active-high reset
//   start       - pulse: IDLE/HALTED -> RUN
//   pc          - fetch address from the pc block
//   stall       - hold inst_out and the ROM address register
//   flush       - squash inst_out on the next edge
//   inst_out    - registered instruction (NOP when not valid)
//   op          - inst_out[8:4], back to the pc block
//   inst_valid  - inst_out holds a real instruction
//   done        - HALT retired
//   fetch_cnt   - delivered-instruction count; live only with FETCH_PERF_CNT_EN
//                 defined, otherwise tied to 0
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned IW        = 9,
   parameter string       INIT_FILE = "machine_code.txt"
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [7:0]    pc,
   input  logic          stall,
   input  logic          flush,
   output logic [IW-1:0] inst_out,
   output logic [4:0]    op,
   output logic          inst_valid,
   output logic          done,
   output logic [15:0]   fetch_cnt
);

   fetch_state_t  state_q, state_d;
   logic [IW-1:0] inst_q, inst_d;
   logic          valid_q, valid_d;
   logic          rom_valid_q, rom_valid_d;  // ROM data register holds a live fetch
   logic          done_q, done_d;
   logic          rd_en;
   logic          deliver;
   logic [IW-1:0] rom_data;

   assign rd_en = (state_q == RUN) && !stall;

   inst_rom #(
      .DEPTH     (DEPTH),
      .IW        (IW),
      .INIT_FILE (INIT_FILE)
   ) u_rom (
      .clk   (clk),
      .addr  (pc),
      .rd_en (rd_en),
      .data  (rom_data)
   );

   assign inst_out   = inst_q;
   assign op         = inst_q[IW-1 -: 5];
   assign inst_valid = valid_q;
   assign done       = done_q;

   always_comb begin
      state_d     = state_q;
      inst_d      = inst_q;
      valid_d     = valid_q;
      rom_valid_d = rom_valid_q;
      done_d      = done_q;
      deliver     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            if (flush) begin
               inst_d      = IW'(NOP);
               valid_d     = 1'b0;
               // A fetch stalled alongside the flush is stale as well
               rom_valid_d = rd_en;
            end else if (valid_q && (op == OP_HALT)) begin
               state_d     = HALTED;
               inst_d      = IW'(NOP);
               valid_d     = 1'b0;
               rom_valid_d = 1'b0;
               done_d      = 1'b1;
            end else if (!stall) begin
               inst_d      = rom_valid_q ? rom_data : IW'(NOP);
               valid_d     = rom_valid_q;
               rom_valid_d = 1'b1;
               deliver     = rom_valid_q;
            end
         end
         HALTED: begin
            if (start) begin
               state_d = RUN;
               done_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         inst_q      <= IW'(NOP);
         valid_q     <= 1'b0;
         rom_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         inst_q      <= inst_d;
         valid_q     <= valid_d;
         rom_valid_q <= rom_valid_d;
         done_q      <= done_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (deliver && (cnt_q != 16'hFFFF)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign fetch_cnt = cnt_q;
`else
   logic unused_deliver;
   assign unused_deliver = deliver;
   assign fetch_cnt      = '0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch (DEPTH=128, ROM loaded hierarchically).
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        reset, start, stall, flush;
   logic [7:0]  pc;
   logic [8:0]  inst_out;
   logic [4:0]  op;
   logic        inst_valid, done;
   logic [15:0] fetch_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   inst_fetch #(
      .DEPTH     (128),
      .IW        (9),
      .INIT_FILE ("")
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pc         (pc),
      .stall      (stall),
      .flush      (flush),
      .inst_out   (inst_out),
      .op         (op),
      .inst_valid (inst_valid),
      .done       (done),
      .fetch_cnt  (fetch_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ec(input int n);
`ifdef FETCH_PERF_CNT_EN
      return 16'(n);
`else
      return 16'd0;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_rom();
      for (int i = 0; i < 128; i++) dut.u_rom.mem[i] = 9'h000;
      dut.u_rom.mem[0]  = 9'h041;
      dut.u_rom.mem[1]  = 9'h082;
      dut.u_rom.mem[2]  = 9'h1F0;
      dut.u_rom.mem[3]  = 9'h0C3;
      dut.u_rom.mem[4]  = 9'h104;
      dut.u_rom.mem[10] = 9'h0AA;
      dut.u_rom.mem[11] = 9'h1F0;
      dut.u_rom.mem[12] = 9'h055;
      dut.u_rom.mem[13] = 9'h1F0;
      dut.u_rom.mem[25] = 9'h0D9;
      dut.u_rom.mem[26] = 9'h0DA;
      dut.u_rom.mem[27] = 9'h1F0;
      dut.u_rom.mem[44] = 9'h12C;
      dut.u_rom.mem[45] = 9'h1F0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; pc = 8'd0;
      step();
      step();
      n_cmp++; if (inst_out !== 9'h000) begin n_bad++; $display("FAIL rst_inst got %h want 000", inst_out); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", inst_valid); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
      n_cmp++; if (op !== 5'h00) begin n_bad++; $display("FAIL rst_op got %h want 00", op); end
      n_cmp++; if (fetch_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_cnt got %0d want 0", fetch_cnt); end
      reset = 1'b0;
      step();
      n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid got %b want 0", inst_valid); end
   endtask

   task automatic test_basic();
      start = 1'b1; pc = 8'd0;
      step();                               // IDLE -> RUN
      start = 1'b0;
      n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL b_lat0 valid got %b want 0", inst_valid); end
      step();                               // ROM samples pc=0
      n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL b_lat1 valid got %b want 0", inst_valid); end
      pc = 8'd1;
      step();
      n_cmp++; if (inst_out !== 9'h041 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL b_i0 got %h/%b want 041/1", inst_out, inst_valid); end
      n_cmp++; if (op !== 5'h04) begin n_bad++; $display("FAIL b_op0 got %h want 04", op); end
      pc = 8'd2;
      step();
      n_cmp++; if (inst_out !== 9'h082 || op !== 5'h08) begin n_bad++; $display("FAIL b_i1 got %h/%h want 082/08", inst_out, op); end
      pc = 8'd3;
      step();
      n_cmp++; if (inst_out !== 9'h1F0 || op !== 5'h1F || done !== 1'b0) begin n_bad++; $display("FAIL b_halt got %h/%h/%b want 1F0/1F/0", inst_out, op, done); end
      step();
      n_cmp++; if (done !== 1'b1 || inst_valid !== 1'b0 || inst_out !== 9'h000) begin n_bad++; $display("FAIL b_done got %b/%b/%h want 1/0/000", done, inst_valid, inst_out); end
      n_cmp++; if (fetch_cnt !== ec(3)) begin n_bad++; $display("FAIL b_cnt got %0d want %0d", fetch_cnt, ec(3)); end
      step();
      n_cmp++; if (done !== 1'b1 || inst_valid !== 1'b0) begin n_bad++; $display("FAIL b_hold got %b/%b want 1/0", done, inst_valid); end
   endtask

   task automatic test_restart();
      // Program 2 at 25
      start = 1'b1; pc = 8'd25;
      step();
      start = 1'b0;
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL r_doneclr got %b want 0", done); end
      step();
      n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL r_lat got %b want 0", inst_valid); end
      pc = 8'd26;
      step();
      n_cmp++; if (inst_out !== 9'h0D9 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL r_25 got %h/%b want 0D9/1", inst_out, inst_valid); end
      pc = 8'd27;
      step();
      n_cmp++; if (inst_out !== 9'h0DA) begin n_bad++; $display("FAIL r_26 got %h want 0DA", inst_out); end
      pc = 8'd28;
      step();
      step();
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL r_done1 got %b want 1", done); end
      n_cmp++; if (fetch_cnt !== ec(6)) begin n_bad++; $display("FAIL r_cnt1 got %0d want %0d", fetch_cnt, ec(6)); end
      // Program 3 at 44
      start = 1'b1; pc = 8'd44;
      step();
      start = 1'b0;
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL r_doneclr2 got %b want 0", done); end
      step();
      pc = 8'd45;
      step();
      n_cmp++; if (inst_out !== 9'h12C || inst_valid !== 1'b1) begin n_bad++; $display("FAIL r_44 got %h/%b want 12C/1", inst_out, inst_valid); end
      pc = 8'd46;
      step();
      step();
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL r_done2 got %b want 1", done); end
      n_cmp++; if (fetch_cnt !== ec(8)) begin n_bad++; $display("FAIL r_cnt2 got %0d want %0d", fetch_cnt, ec(8)); end
   endtask

   task automatic test_stall();
      start = 1'b1; pc = 8'd0;
      step();
      start = 1'b0;
      step();
      pc = 8'd1;
      step();                               // inst_out = 041
      pc = 8'd2;
      step();                               // inst_out = 082
      n_cmp++; if (inst_out !== 9'h082) begin n_bad++; $display("FAIL s_pre got %h want 082", inst_out); end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (inst_out !== 9'h082 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL s_hold%0d got %h/%b want 082/1", i, inst_out, inst_valid); end
         n_cmp++; if (fetch_cnt !== ec(10)) begin n_bad++; $display("FAIL s_cnt%0d got %0d want %0d", i, fetch_cnt, ec(10)); end
      end
      stall = 1'b0; pc = 8'd3;
      step();
      n_cmp++; if (inst_out !== 9'h1F0 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL s_rel got %h/%b want 1F0/1", inst_out, inst_valid); end
      n_cmp++; if (fetch_cnt !== ec(11)) begin n_bad++; $display("FAIL s_cnt_rel got %0d want %0d", fetch_cnt, ec(11)); end
      step();
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL s_done got %b want 1", done); end
   endtask

   task automatic test_flush();
      start = 1'b1; pc = 8'd10;
      step();
      start = 1'b0;
      step();
      pc = 8'd11;
      step();                               // inst_out = 0AA
      pc = 8'd12;
      step();                               // inst_out = HALT
      n_cmp++; if (inst_out !== 9'h1F0 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL f_pre got %h/%b want 1F0/1", inst_out, inst_valid); end
      flush = 1'b1; stall = 1'b1;
      step();
      n_cmp++; if (inst_out !== 9'h000 || inst_valid !== 1'b0 || op !== 5'h00) begin n_bad++; $display("FAIL f_squash got %h/%b/%h want 000/0/00", inst_out, inst_valid, op); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL f_done0 got %b want 0", done); end
      flush = 1'b0; stall = 1'b0;
      step();                               // ROM samples 12
      n_cmp++; if (inst_valid !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL f_gap got %b/%b want 0/0", inst_valid, done); end
      pc = 8'd13;
      step();
      n_cmp++; if (inst_out !== 9'h055 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL f_tgt got %h/%b want 055/1", inst_out, inst_valid); end
      pc = 8'd14;
      step();
      step();
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL f_done got %b want 1", done); end
      n_cmp++; if (fetch_cnt !== ec(15)) begin n_bad++; $display("FAIL f_cnt got %0d want %0d", fetch_cnt, ec(15)); end
   endtask

   task automatic test_reset_mid();
      start = 1'b1; pc = 8'd3;
      step();
      start = 1'b0;
      step();
      pc = 8'd4;
      step();                               // inst_out = 0C3
      n_cmp++; if (inst_out !== 9'h0C3 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL m_pre got %h/%b want 0C3/1", inst_out, inst_valid); end
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (inst_valid !== 1'b0 || done !== 1'b0 || inst_out !== 9'h000) begin n_bad++; $display("FAIL m_async got %b/%b/%h want 0/0/000", inst_valid, done, inst_out); end
      n_cmp++; if (fetch_cnt !== 16'd0) begin n_bad++; $display("FAIL m_cnt got %0d want 0", fetch_cnt); end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL m_idle%0d got %b want 0", i, inst_valid); end
      end
   endtask

   task automatic test_out_of_range();
      start = 1'b1; pc = 8'd3;
      step();
      start = 1'b0;
      step();
      pc = 8'd4;
      step();
      n_cmp++; if (inst_out !== 9'h0C3 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL o_resume got %h/%b want 0C3/1", inst_out, inst_valid); end
      pc = 8'hFF;
      step();
      n_cmp++; if (inst_out !== 9'h104) begin n_bad++; $display("FAIL o_104 got %h want 104", inst_out); end
      pc = 8'd0;
      step();
      n_cmp++; if (inst_out !== 9'h000 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL o_ff got %h/%b want 000/1", inst_out, inst_valid); end
      pc = 8'd1;
      step();
      n_cmp++; if (inst_out !== 9'h041 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL o_wrap got %h/%b want 041/1", inst_out, inst_valid); end
      n_cmp++; if (fetch_cnt !== ec(4)) begin n_bad++; $display("FAIL o_cnt got %0d want %0d", fetch_cnt, ec(4)); end
   endtask

   initial begin
      load_rom();
      test_reset();
      test_basic();
      test_restart();
      test_stall();
      test_flush();
      test_reset_mid();
      test_out_of_range();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
